// File: rtl/pipeline_control_unit_pkg.sv
// Shared constants and types for the pipeline control unit.
//   Opcode/funct encodings, ALU control codes, forward-select codes,
//   the shadow-stage record and the forward-select helper.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned FWD_W = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  localparam logic [FWD_W-1:0] FWD_RF    = 2'd0;
  localparam logic [FWD_W-1:0] FWD_ALU_E = 2'd1;
  localparam logic [FWD_W-1:0] FWD_MEM_M = 2'd2;
  localparam logic [FWD_W-1:0] FWD_ALU_M = 2'd3;

  // In-flight instruction record; reg_write is already cleared for $0 writes.
  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic             mem2reg;
    logic [REG_W-1:0] dest;
  } shadow_t;

  // Forward select for one decode-stage source; E wins over M.
  function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src,
                                                input logic             used,
                                                input shadow_t          e,
                                                input shadow_t          m);
    logic [FWD_W-1:0] sel;
    sel = FWD_RF;
    if (used && (src != '0)) begin
      if (e.reg_write && (e.dest == src) && !e.mem2reg) sel = FWD_ALU_E;
      else if (m.reg_write && (m.dest == src))          sel = m.mem2reg ? FWD_MEM_M : FWD_ALU_M;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_control_unit_if.sv
// Control/hazard interface between datapath (master) and control unit (slave).
//   master drives the decode-stage instruction fields and eq;
//   slave returns control bits, forward selects, stall/flush and counters.
interface pipeline_control_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rsD;
  logic [4:0]       rtD;
  logic [4:0]       rdD;
  logic             eq;
  logic             regWrite;
  logic             regDst;
  logic             memWrite;
  logic             mem2Reg;
  logic             aluSrcB;
  logic [2:0]       aluControl;
  logic             pcSrc;
  logic [1:0]       fad;
  logic [1:0]       fbd;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] retired;
  logic [CNT_W-1:0] stallCycles;

  modport master (
    output opcode, funct, rsD, rtD, rdD, eq,
    input  regWrite, regDst, memWrite, mem2Reg, aluSrcB, aluControl,
           pcSrc, fad, fbd, stall, flush, retired, stallCycles
  );

  modport slave (
    input  opcode, funct, rsD, rtD, rdD, eq,
    output regWrite, regDst, memWrite, mem2Reg, aluSrcB, aluControl,
           pcSrc, fad, fbd, stall, flush, retired, stallCycles
  );
endinterface

// File: rtl/pipeline_control_unit_ctrl_main_decoder.sv
// Combinational main decoder: opcode/funct -> datapath controls,
//   valid flag and source-usage flags. Unknown encodings decode as NOP.
module ctrl_main_decoder
  import pipeline_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic [OP_W-1:0]  funct,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_write,
  output logic             mem2reg,
  output logic             alu_src_b,
  output logic [ALU_W-1:0] alu_control,
  output logic             branch,
  output logic             valid,
  output logic             use_rs,
  output logic             use_rt
);

  logic             rtype_ok;
  logic [ALU_W-1:0] rtype_alu;

  // Decode an R-type funct field; unknown funct leaves rtype_ok low.
  always_comb begin
    rtype_ok  = 1'b1;
    rtype_alu = ALU_AND;
    case (funct)
      FN_ADD:  rtype_alu = ALU_ADD;
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_SLT:  rtype_alu = ALU_SLT;
      default: rtype_ok  = 1'b0;
    endcase
  end

  // Main opcode decode.
  always_comb begin
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_write   = 1'b0;
    mem2reg     = 1'b0;
    alu_src_b   = 1'b0;
    alu_control = ALU_AND;
    branch      = 1'b0;
    valid       = 1'b0;
    use_rs      = 1'b0;
    use_rt      = 1'b0;
    case (opcode)
      OP_RTYPE: if (rtype_ok) begin
        valid = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        reg_write = 1'b1; reg_dst = 1'b1; alu_control = rtype_alu;
      end
      OP_LW: begin
        valid = 1'b1; use_rs = 1'b1;
        reg_write = 1'b1; mem2reg = 1'b1; alu_src_b = 1'b1; alu_control = ALU_ADD;
      end
      OP_SW: begin
        valid = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        mem_write = 1'b1; alu_src_b = 1'b1; alu_control = ALU_ADD;
      end
      OP_BEQ: begin
        valid = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
        branch = 1'b1; alu_control = ALU_SUB;
      end
      OP_ADDI: begin
        valid = 1'b1; use_rs = 1'b1;
        reg_write = 1'b1; alu_src_b = 1'b1; alu_control = ALU_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline control unit: main decode, forwarding selects, load-use stall,
//   branch resolve/flush, E/M shadow pipeline and performance counters.
//   Ports: clk, rst_n (async active-low), bus (slave modport of
//   pipeline_control_unit_if carrying instrD fields, eq and all controls).
module pipeline_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipeline_control_unit_if.slave  bus
);

  logic             dec_reg_write, dec_reg_dst, dec_mem_write, dec_mem2reg;
  logic             dec_alu_src_b, dec_branch, dec_valid, dec_use_rs, dec_use_rt;
  logic [ALU_W-1:0] dec_alu_control;
  logic [REG_W-1:0] dst_dec;
  logic             stall_c;
  logic             pc_src_c;

  shadow_t          e_q, e_d;
  shadow_t          m_q, m_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  ctrl_main_decoder u_dec (
    .opcode      (bus.opcode),
    .funct       (bus.funct),
    .reg_write   (dec_reg_write),
    .reg_dst     (dec_reg_dst),
    .mem_write   (dec_mem_write),
    .mem2reg     (dec_mem2reg),
    .alu_src_b   (dec_alu_src_b),
    .alu_control (dec_alu_control),
    .branch      (dec_branch),
    .valid       (dec_valid),
    .use_rs      (dec_use_rs),
    .use_rt      (dec_use_rt)
  );

  // Hazard detection, branch resolve and next shadow/counter state.
  always_comb begin
    dst_dec = dec_reg_dst ? bus.rdD : bus.rtD;

    // Only a load in E can't be forwarded in time; hold D for one cycle.
    stall_c = e_q.reg_write && e_q.mem2reg && (e_q.dest != '0) &&
              ((dec_use_rs && (bus.rsD == e_q.dest)) ||
               (dec_use_rt && (bus.rtD == e_q.dest)));

    pc_src_c = dec_branch && bus.eq && !stall_c;

    e_d = '0;
    if (!stall_c) begin
      e_d.valid     = dec_valid;
      e_d.reg_write = dec_reg_write && (dst_dec != '0);
      e_d.mem2reg   = dec_mem2reg;
      e_d.dest      = dst_dec;
    end
    m_d = e_q;

    retired_d   = retired_q + CNT_W'(m_q.valid);
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q         <= '0;
      m_q         <= '0;
      retired_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      m_q         <= m_d;
      retired_q   <= retired_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // A stalled instruction becomes a bubble in E, so its side effects are masked.
  assign bus.regWrite    = dec_reg_write && !stall_c;
  assign bus.memWrite    = dec_mem_write && !stall_c;
  assign bus.regDst      = dec_reg_dst;
  assign bus.mem2Reg     = dec_mem2reg;
  assign bus.aluSrcB     = dec_alu_src_b;
  assign bus.aluControl  = dec_alu_control;
  assign bus.pcSrc       = pc_src_c;
  assign bus.flush       = pc_src_c;
  assign bus.stall       = stall_c;
  assign bus.fad         = fwd_sel(bus.rsD, dec_use_rs, e_q, m_q);
  assign bus.fbd         = fwd_sel(bus.rtD, dec_use_rt, e_q, m_q);
  assign bus.retired     = retired_q;
  assign bus.stallCycles = stall_cnt_q;

endmodule
